crc_check_sched: RTL



---
 rtl/crc_pkg.sv | 24 ++
 rtl/crc_sched_cnt.sv | 34 +++
 rtl/crc_check_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC check scheduler, the CRC scan engine and the
// data memory: controller state encoding, widths and saturation limits.
package crc_pkg;

    localparam int CRC_W_DEFAULT = 16;
    localparam int MEM_DEPTH     = 1024;
    localparam int ADDR_W        = 10;

    localparam logic [7:0] FAIL_CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOST    = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_COMPARE = 3'd4
    } crc_sched_state_t;

    // Failure counter increment that sticks at FAIL_CNT_MAX.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == FAIL_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/crc_sched_cnt.sv
// Generic up-counter: synchronous clear, count enable, and a terminal-count
// flag that is high while the count equals LAST. Wraps to 0 after LAST.
module crc_sched_cnt #(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count_q, count_d;

    assign tc = (count_q == LAST);

    // Next count: clear wins over enable; wrap after the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/crc_check_sched.sv
// CRC check scheduler: arbitrates the memory port between the host writer and
// the CRC scan engine, launches checks, times out a stuck engine and posts
// pass/fail results with a saturating failure count.
// Optional build macro CRC_SCHED_PERIODIC_EN adds a free-running period
// counter that requests a check every PERIOD_CYCLES cycles.
//
// Handshake: check_req and crc_rdy are single-cycle pulses sampled on the
// rising clock edge; crc_value is valid only with crc_rdy and crc_rdy outside
// RUN is ignored; crc_start and done are single-cycle pulses; host_req is a
// level and host_gnt stays high for as long as the host holds host_req.
module crc_check_sched
    import crc_pkg::*;
#(
    parameter int CRC_W          = CRC_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PERIOD_CYCLES  = 50_000_000
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic             check_req,
    input  logic             host_req,
    output logic             host_gnt,
    output logic             mem_sel_host,
    output logic             crc_start,
    input  logic             crc_rdy,
    input  logic [CRC_W-1:0] crc_value,
    input  logic [CRC_W-1:0] crc_ref,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             err_timeout,
    output logic [7:0]       fail_cnt
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    crc_sched_state_t state_q, state_d;
    logic             pending_q, pending_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [7:0]       fail_cnt_q, fail_cnt_d;
    logic             to_tc;
    logic             period_wrap;

    // Timeout counter: zeroed in START, counts every RUN cycle.
    crc_sched_cnt #(
        .WIDTH (TO_W),
        .LAST  (TO_W'(TIMEOUT_CYCLES - 1))
    ) u_timeout (
        .clk   (clk50m),
        .rst_n (rst_n),
        .clr   (state_q == ST_START),
        .en    (state_q == ST_RUN),
        .tc    (to_tc)
    );

`ifdef CRC_SCHED_PERIODIC_EN
    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    // Free-running period counter; each wrap raises a check request.
    crc_sched_cnt #(
        .WIDTH (PER_W),
        .LAST  (PER_W'(PERIOD_CYCLES - 1))
    ) u_period (
        .clk   (clk50m),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (1'b1),
        .tc    (period_wrap)
    );
`else
    // No periodic source; the parameter stays in the list so both builds
    // share one interface.
    assign period_wrap = 1'b0 && (PERIOD_CYCLES > 0);
`endif

    // Next-state and result logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | check_req | period_wrap;
        crc_d      = crc_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_d      = err_q;
        done_d     = 1'b0;
        fail_cnt_d = fail_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (host_req)                     state_d = ST_HOST;
                else if (pending_q || check_req)  state_d = ST_START;
            end
            ST_HOST: begin
                if (!host_req) state_d = ST_IDLE;
            end
            ST_START: begin
                pass_d  = 1'b0;
                fail_d  = 1'b0;
                err_d   = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A result on the last allowed cycle still counts.
                if (crc_rdy) begin
                    crc_d   = crc_value;
                    state_d = ST_COMPARE;
                end else if (to_tc) begin
                    err_d      = 1'b1;
                    fail_d     = 1'b1;
                    done_d     = 1'b1;
                    fail_cnt_d = sat_inc(fail_cnt_q);
                    state_d    = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                done_d = 1'b1;
                pass_d = (crc_q == crc_ref);
                fail_d = (crc_q != crc_ref);
                if (crc_q != crc_ref) fail_cnt_d = sat_inc(fail_cnt_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering START consumes every request coalesced so far.
        if (state_d == ST_START) pending_d = 1'b0;
    end

    // State and result registers; reset aborts any check in flight.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            crc_q      <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            fail_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            crc_q      <= crc_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            done_q     <= done_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign host_gnt     = (state_q == ST_HOST);
    assign mem_sel_host = (state_q == ST_HOST);
    assign crc_start    = (state_q == ST_START);
    assign busy         = (state_q == ST_START) || (state_q == ST_RUN) ||
                          (state_q == ST_COMPARE);
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign err_timeout  = err_q;
    assign fail_cnt     = fail_cnt_q;

endmodule
